input_buffer_fifo: RTL and testbench



---
 rtl/input_buffer_fifo.sv | 94 +++++++++
 tb/tb_input_buffer_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_fifo.sv
// Per-port router input buffer: power-of-two circular FIFO with a first-word-fall-through head,
// occupancy status for upstream flow control, and sticky overflow/underflow flags.
module input_buffer_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_W:0] FullCnt   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AlmostCnt = (ADDR_W + 1)'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FullCnt);
    assign almost_full = (count_q >= AlmostCnt);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign Data_out    = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full buffer still accepts a concurrent push.
    // An empty buffer never pops, even if a push lands in the same cycle (no bypass).
    assign pop  = read && !empty;
    assign push = write && (!full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (write && !push) begin
            overflow_d = 1'b1;
        end
        if (read && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

endmodule

// File: tb/tb_input_buffer_fifo.sv
// Self-checking bench for input_buffer_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_input_buffer_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          write;
    logic [DW-1:0] Data_in;
    logic          read;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_unf;

    input_buffer_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .Data_in    (Data_in),
        .read       (read),
        .Data_out   (Data_out),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the reference model across the edge, then settle for sampling.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic rn);
        bit m_pop, m_push;
        write   = w;
        Data_in = d;
        read    = r;
        rst_n   = rn;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_pop  = r && (mq.size() != 0);
            m_push = w && ((mq.size() < DEPTH) || m_pop);
            if (r && mq.size() == 0) m_unf = 1'b1;
            if (w && !m_push) m_ovf = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (Data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", Data_out); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almost_full); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_fill();
        cycle(1'b1, 8'h15, 1'b0, 1'b1);
        checks++; if (Data_out !== 8'h15) begin errors++; $display("FAIL fill_head got %h want 15", Data_out); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %b want 0", empty); end
        cycle(1'b1, 8'h26, 1'b0, 1'b1);
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_afull2 got %b want 0", almost_full); end
        cycle(1'b1, 8'h37, 1'b0, 1'b1);
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull3 got %b want 1", almost_full); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full3 got %b want 0", full); end
        cycle(1'b1, 8'h48, 1'b0, 1'b1);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full4 got %b want 1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        checks++; if (Data_out !== 8'h15) begin errors++; $display("FAIL fill_head4 got %h want 15", Data_out); end
    endtask

    task automatic test_overflow_drain();
        logic [DW-1:0] exp_seq [4];
        exp_seq = '{8'h15, 8'h26, 8'h37, 8'h48};
        cycle(1'b1, 8'h59, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (Data_out !== exp_seq[i]) begin
                errors++; $display("FAIL drain_data%0d got %h want %h", i, Data_out, exp_seq[i]);
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
        checks++; if (Data_out !== 8'h00) begin errors++; $display("FAIL drain_data_empty got %h want 00", Data_out); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp_seq [8];
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1);
        exp_seq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h60, 8'h61, 8'h62, 8'h63};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (Data_out !== exp_seq[i]) begin
                errors++; $display("FAIL fullrw_data%0d got %h want %h", i, Data_out, exp_seq[i]);
            end
            cycle(1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
            checks++;
            if ({full, count} !== {1'b1, 3'd4}) begin
                errors++; $display("FAIL fullrw_occ%0d got full=%b count=%0d want full=1 count=4", i, full, count);
            end
        end
    endtask

    task automatic test_empty_rw();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hA3, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL erw_unf got %b want 1", underflow); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL erw_count got %0d want 1", count); end
        checks++; if (Data_out !== 8'hA3) begin errors++; $display("FAIL erw_data got %h want a3", Data_out); end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL erw_empty got %b want 1", empty); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL erw_unf_sticky got %b want 1", underflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if ({overflow, underflow, count} !== {2'b11, 3'd2}) begin
            errors++; $display("FAIL mid_pre got ovf=%b unf=%b count=%0d want 1 1 2", overflow, underflow, count);
        end
        cycle(1'b1, 8'h01, 1'b0, 1'b1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
        checks++; if (Data_out !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", Data_out); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b%b want 00", overflow, underflow); end
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        checks++; if ({Data_out, count} !== {8'h11, 3'd1}) begin
            errors++; $display("FAIL mid_after got data=%h count=%0d want 11 1", Data_out, count);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_data;
        logic [AW:0]   exp_count;
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 59) != 0));
            exp_data  = (mq.size() != 0) ? mq[0] : 8'h00;
            exp_count = (AW + 1)'(mq.size());
            checks++;
            if ({Data_out, count, empty, full, almost_full, overflow, underflow} !==
                {exp_data, exp_count, mq.size() == 0, mq.size() == DEPTH, mq.size() >= DEPTH - 1,
                 m_ovf, m_unf}) begin
                errors++;
                $display("FAIL rand%0d got data=%h cnt=%0d e=%b f=%b af=%b o=%b u=%b want data=%h cnt=%0d o=%b u=%b",
                         n, Data_out, count, empty, full, almost_full, overflow, underflow,
                         exp_data, exp_count, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        Data_in = '0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
